// File: rtl/multi_op_shift_controller_if.sv
// Control/handshake bundle between the top-level controller interface and
// the shift/accumulate sequencer. The master side issues jobs and accepts
// results. The slave side is the sequencer, which drives the datapath strobes.
interface multi_op_shift_controller_if #(
  parameter int IDX_W = 2,
  parameter int SH_W  = 2
);
  // Job request and result-acceptance signals
  logic             start;
  logic             abort;
  logic             shift_dir;
  logic [SH_W-1:0]  shift_amt;
  logic             out_ready;

  // Datapath strobes and status
  logic             rst_out;
  logic             ld_A;
  logic             ld_B;
  logic             l_1;
  logic             l_2;
  logic [1:0]       shctrl;
  logic             ld_out;
  logic             out_valid;
  logic [IDX_W-1:0] op_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, shift_dir, shift_amt, out_ready,
    input  rst_out, ld_A, ld_B, l_1, l_2, shctrl, ld_out, out_valid,
           op_idx, busy, done
  );

  modport slave (
    input  start, abort, shift_dir, shift_amt, out_ready,
    output rst_out, ld_A, ld_B, l_1, l_2, shctrl, ld_out, out_valid,
           op_idx, busy, done
  );
endinterface

// File: rtl/multi_op_shift_controller.sv
// Sequencing FSM for the shift/accumulate datapath. Each start runs a job of
// N_OPS operand pairs. Every operand is loaded and then shifted for a captured
// number of cycles in a captured direction. The operand is then accumulated,
// and the result is offered downstream on a valid/ready handshake. Outputs are
// a Moore decode of the state register. An abort cancels the job without
// pulsing done.
module multi_op_shift_controller #(
  parameter int N_OPS     = 4,
  parameter int MAX_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  multi_op_shift_controller_if.slave bus
);

  localparam int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int SH_W  = $clog2(MAX_SHIFT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPS - 1);
  localparam logic [SH_W-1:0]  SH_MAX   = SH_W'(MAX_SHIFT);
  localparam logic [SH_W-1:0]  SH_ONE   = SH_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_SHIFT,
    S_ACC,
    S_OUT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [SH_W-1:0]  cnt_q, cnt_nxt;
  logic [SH_W-1:0]  amt_q, amt_nxt;
  logic             dir_q, dir_nxt;
  logic [SH_W-1:0]  amt_clamped;

  // Saturate the requested shift count at MAX_SHIFT. When the port width
  // cannot represent anything larger, no comparator is needed.
  generate
    if (MAX_SHIFT == (1 << SH_W) - 1) begin : g_no_clamp
      assign amt_clamped = bus.shift_amt;
    end else begin : g_clamp
      assign amt_clamped = (bus.shift_amt > SH_MAX) ? SH_MAX : bus.shift_amt;
    end
  endgenerate

  // State, operand index, shift counter and captured job parameters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx_q <= '0;
      cnt_q <= '0;
      amt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, so the order of these lines does not matter.
      state <= state_nxt;
      idx_q <= idx_nxt;
      cnt_q <= cnt_nxt;
      amt_q <= amt_nxt;
      dir_q <= dir_nxt;
    end
  end

  // Next-state and next-data decode; abort preempts every busy state
  always_comb begin
    // NOTE: every target gets a hold value first, so paths that leave a
    // signal unassigned cannot infer a latch.
    state_nxt = state;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    amt_nxt   = amt_q;
    dir_nxt   = dir_q;

    if (state != S_IDLE && bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          // start is ignored when abort is asserted in the same cycle
          if (bus.start && !bus.abort) begin
            dir_nxt   = bus.shift_dir;
            amt_nxt   = amt_clamped;
            idx_nxt   = '0;
            state_nxt = S_INIT;
          end
        end
        S_INIT: begin
          idx_nxt   = '0;
          state_nxt = S_LOAD;
        end
        S_LOAD: begin
          cnt_nxt   = amt_q;
          state_nxt = (amt_q != '0) ? S_SHIFT : S_ACC;
        end
        S_SHIFT: begin
          cnt_nxt = cnt_q - SH_ONE;
          // The count is at least 1 on entry, so this state takes amt cycles
          if (cnt_q <= SH_ONE) state_nxt = S_ACC;
        end
        S_ACC: begin
          state_nxt = S_OUT;
        end
        S_OUT: begin
          // Stall here until downstream accepts the result
          if (bus.out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_nxt = S_DONE;
            end else begin
              idx_nxt   = idx_q + IDX_W'(1);
              state_nxt = S_LOAD;
            end
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Moore output decode; IDLE (including reset) drives every output low
  always_comb begin
    bus.rst_out   = 1'b0;
    bus.ld_A      = 1'b0;
    bus.ld_B      = 1'b0;
    bus.l_1       = 1'b0;
    bus.l_2       = 1'b0;
    bus.shctrl    = 2'b00;
    bus.ld_out    = 1'b0;
    bus.out_valid = 1'b0;
    bus.op_idx    = (state == S_IDLE) ? '0 : idx_q;
    bus.busy      = (state != S_IDLE);
    bus.done      = 1'b0;

    unique case (state)
      S_INIT:  bus.rst_out = 1'b1;
      S_LOAD: begin
        bus.ld_A = 1'b1;
        bus.ld_B = 1'b1;
        // The first operand is a fresh load, not an accumulate
        bus.l_2  = (idx_q == '0);
      end
      S_SHIFT: bus.shctrl = dir_q ? 2'b10 : 2'b01;
      S_ACC: begin
        bus.l_1    = 1'b1;
        bus.ld_out = 1'b1;
      end
      S_OUT:   bus.out_valid = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
